// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding memory port with fixed read latency LAT.
// Optional fetch starvation guard is compiled in when ARB_STARVE_GUARD_EN is defined.
module mem_port_arbiter #(
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_type,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_type,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] WAIT_LAST = 2'(LAT - 1);

  if (LAT < 1 || LAT > 4 || STARVE_MAX < 1) begin : g_param_check
    $error("mem_port_arbiter: LAT must be 1..4 and STARVE_MAX at least 1");
  end

  state_t      state, state_nx;
  logic        any_req;
  logic        pick_data;
  logic        grant_data;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_type;
  logic [1:0]  wait_cnt;

  assign any_req = if_req | d_req;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic          starve_force;

  assign starve_force = (starve_cnt == SW'(STARVE_MAX)) && if_req && d_req;
  assign pick_data    = d_req && !starve_force;

  // Counts data grants that overtook a waiting fetch; any fetch grant clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (!pick_data)
        starve_cnt <= '0;
      else if (if_req && starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  assign pick_data = d_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Requests are sampled only in IDLE; the latched copy drives the whole transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_data <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_type   <= '0;
      wait_cnt   <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_data <= pick_data;
        lat_we     <= pick_data && d_we;
        lat_addr   <= pick_data ? d_addr : if_addr;
        lat_wdata  <= pick_data ? d_wdata : 32'h0;
        lat_type   <= pick_data ? d_type : 3'b010;
      end
      if (state == WAIT) begin
        if (wait_cnt == WAIT_LAST) begin
          wait_cnt <= '0;
          if (grant_data) d_rdata  <= mem_rdata;
          else            if_rdata <= mem_rdata;
        end else begin
          wait_cnt <= wait_cnt + 2'd1;
        end
      end
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_type  = '0;
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nx = ISSUE;
      end
      ISSUE: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_type  = lat_type;
        state_nx  = lat_we ? DONE : WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (wait_cnt == WAIT_LAST) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        if_ready = !grant_data;
        d_ready  = grant_data;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL provide parameter LAT, default 2, memory read latency in cycles, legal range 1..4.
REQ-002 The block SHALL provide parameter STARVE_MAX, default 4, maximum consecutive data grants while fetch waits.
REQ-003 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  32  fetch address
- if_rdata  out  32  fetch read data
- if_ready  out  1  fetch completion pulse
- d_req  in  1  data request, held until d_ready
- d_we  in  1  data write enable
- d_addr  in  32  data address
- d_wdata  in  32  data write data
- d_type  in  3  DMType access size code
- d_rdata  out  32  data read data
- d_ready  out  1  data completion pulse
- mem_en  out  1  memory strobe
- mem_we  out  1  memory write
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_type  out  3  memory access size code
- mem_rdata  in  32  memory read data
- busy  out  1  transaction in flight

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE; busy SHALL be high in every state except IDLE.
REQ-005 In IDLE with any request high, the FSM SHALL select a grantee, latch its addr/we/wdata/type, and move to ISSUE on the next cycle.
REQ-006 Arbitration SHALL be fixed-priority: data wins over fetch, subject to REQ-015.
REQ-007 In ISSUE, mem_en SHALL be 1 for exactly that one cycle, with mem_addr, mem_we, mem_wdata and mem_type driven from the latched values; fetch issues SHALL force mem_we=0 and mem_type=3'b010 (word).
REQ-008 From ISSUE, a write SHALL go to DONE; a read SHALL go to WAIT.
REQ-009 WAIT SHALL last exactly LAT cycles, counted by an internal counter; mem_rdata SHALL be captured in the last WAIT cycle, which is ISSUE cycle + LAT.
REQ-010 In DONE, exactly one of if_ready or d_ready (the grantee's) SHALL be 1 for one cycle, and the FSM SHALL return to IDLE.
REQ-011 Timing from request detected in IDLE at cycle 0: a read SHALL complete with ready at cycle LAT+2, a write with ready at cycle 2.
REQ-012 if_rdata and d_rdata SHALL be registered and hold their last captured value until that port's next read completes.
REQ-013 mem_* outputs SHALL be 0 whenever mem_en is 0.
REQ-014 Request changes during ISSUE, WAIT or DONE SHALL NOT affect the transaction in flight:
- a request dropped mid-transaction still completes, with ready pulsed;
- a new request is sampled only in IDLE.

Reset
REQ-016 Asserting reset at any time, including mid-transaction, SHALL immediately force state IDLE, counters to 0, and all outputs to 0 (rdata registers included).
REQ-017 An aborted transaction SHALL NOT produce a ready pulse after reset deasserts.

Configuration
REQ-015 With ARB_STARVE_GUARD_EN defined, the starvation guard SHALL be compiled in:
- a counter increments on each data grant made while if_req=1;
- the counter clears on each fetch grant;
- when the counter equals STARVE_MAX and both requests are high, fetch SHALL be granted.
Without ARB_STARVE_GUARD_EN, arbitration SHALL be strictly data-first and no counter SHALL exist.

Verification (LAT=2)
REQ-018 Fetch read, if_addr=0x40, mem_rdata=0x00A00093 -> mem_en at cycle 1, if_ready at cycle 4, if_rdata=0x00A00093.
REQ-019 Data write, d_addr=0x100, d_wdata=0xDEADBEEF, d_type=3'b010 -> mem_en=mem_we=1 at cycle 1, d_ready at cycle 2, if_ready never asserted.
REQ-020 if_req and d_req rise together -> data granted first, and fetch ISSUE follows the data DONE + IDLE.
REQ-021 Reset pulsed during WAIT of a data read -> busy=0 and d_ready=0 immediately, and no ready pulse after release.
REQ-022 With ARB_STARVE_GUARD_EN, STARVE_MAX=4, both requests held high -> four data grants, then one fetch grant, then data again; without the macro, fetch is never granted.
REQ-023 LAT=4 data read -> d_ready exactly 6 cycles after the request is detected in IDLE.
